// File: rtl/as_pack.sv
// Shared constants and types for the RV64I in-order pipeline front end.
package as_pack;
    localparam int XLEN = 64;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_KILL,
        S_HOLD
    } fetch_state_t;

    typedef enum logic [1:0] {
        IFID_HOLD,
        IFID_FLUSH,
        IFID_LOAD,
        IFID_BUBBLE
    } if_id_op_t;
endpackage

// File: rtl/as_if_id_reg.sv
// IF/ID pipeline register: hold, flush, bubble or load one fetched instruction.
module as_if_id_reg
    import as_pack::*;
(
    input  logic            clk,
    input  logic            rst,
    input  if_id_op_t       op,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic            valid,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [31:0]     instr
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else begin
            case (op)
                IFID_FLUSH, IFID_BUBBLE: begin
                    // pc is left alone so the last real PC stays visible
                    valid <= 1'b0;
                    instr <= NOP_INSTR;
                end
                IFID_LOAD: begin
                    valid <= 1'b1;
                    pc    <= load_pc;
                    instr <= load_instr;
                end
                default: ;
            endcase
        end
    end

    assign pc4 = pc + XLEN'(4);
endmodule

// File: rtl/as_fetch_stage.sv
// Instruction-fetch stage: PC, imem request/ack handshake, redirect and stall handling.
module as_fetch_stage
    import as_pack::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_n_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] branch_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o
);
    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] redir_q, redir_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    if_id_op_t       if_op;
    logic [XLEN-1:0] load_pc;
    logic [31:0]     load_instr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_BOOT;
            pc_q        <= RESET_PC;
            redir_q     <= '0;
            buf_pc_q    <= '0;
            buf_instr_q <= NOP_INSTR;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            redir_q     <= redir_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        redir_d     = redir_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        imem_req_o  = 1'b0;
        load_pc     = pc_q;
        load_instr  = imem_rdata_i;
        // IF/ID priority: flush beats stall, stall beats any load or bubble
        if (flush_i)         if_op = IFID_FLUSH;
        else if (!stall_n_i) if_op = IFID_HOLD;
        else                 if_op = IFID_BUBBLE;

        case (state_q)
            S_BOOT: state_d = S_REQ;
            S_REQ: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    if (flush_i) begin
                        pc_d = branch_target_i;
                    end else if (!stall_n_i) begin
                        buf_pc_d    = pc_q;
                        buf_instr_d = imem_rdata_i;
                        state_d     = S_HOLD;
                    end else begin
                        if_op = IFID_LOAD;
                        pc_d  = pc_q + XLEN'(4);
                    end
                end else if (flush_i) begin
                    redir_d = branch_target_i;
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                // the outstanding request must complete before redirecting
                imem_req_o = 1'b1;
                if (flush_i) redir_d = branch_target_i;
                if (imem_ack_i) begin
                    pc_d    = flush_i ? branch_target_i : redir_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    pc_d    = branch_target_i;
                    state_d = S_REQ;
                end else if (stall_n_i) begin
                    if_op      = IFID_LOAD;
                    load_pc    = buf_pc_q;
                    load_instr = buf_instr_q;
                    pc_d       = buf_pc_q + XLEN'(4);
                    state_d    = S_REQ;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    assign imem_addr_o = pc_q;

    as_if_id_reg u_if_id (
        .clk        (clk_i),
        .rst        (rst_i),
        .op         (if_op),
        .load_pc    (load_pc),
        .load_instr (load_instr),
        .valid      (if_id_valid_o),
        .pc         (if_id_pc_o),
        .pc4        (if_id_pc4_o),
        .instr      (if_id_instr_o)
    );
endmodule

// File: tb/tb_as_fetch_stage.sv
// Self-checking bench for as_fetch_stage: cycle vector table plus a delivered-instruction scoreboard.
module tb_as_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NV = 23;

    logic        clk = 1'b0;
    logic        rst, stall_n, flush, ack;
    logic [63:0] target;

    logic        m_req, m_valid, w_req, w_valid;
    logic [63:0] m_addr, m_pc, m_pc4, w_addr, w_pc, w_pc4;
    logic [31:0] m_rdata, m_instr, w_rdata, w_instr;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        stall_n;
        logic        flush;
        logic [63:0] target;
        logic        ack;
        logic        push;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t        vecs[NV];
    logic [63:0] sb_q[$];
    logic        prev_valid;
    logic [63:0] prev_pc;

    function automatic logic [31:0] word(input logic [63:0] a);
        logic [31:0] lo;
        lo = a[31:0];
        return lo ^ 32'h5A5A_0003;
    endfunction

    assign m_rdata = word(m_addr);
    assign w_rdata = word(w_addr);

    always #5 clk = ~clk;

    as_fetch_stage u_dut (
        .clk_i(clk), .rst_i(rst), .stall_n_i(stall_n), .flush_i(flush),
        .branch_target_i(target), .imem_req_o(m_req), .imem_addr_o(m_addr),
        .imem_ack_i(ack), .imem_rdata_i(m_rdata), .if_id_valid_o(m_valid),
        .if_id_pc_o(m_pc), .if_id_pc4_o(m_pc4), .if_id_instr_o(m_instr)
    );

    as_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
        .clk_i(clk), .rst_i(rst), .stall_n_i(stall_n), .flush_i(flush),
        .branch_target_i(target), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_ack_i(ack), .imem_rdata_i(w_rdata), .if_id_valid_o(w_valid),
        .if_id_pc_o(w_pc), .if_id_pc4_o(w_pc4), .if_id_instr_o(w_instr)
    );

    function automatic vec_t mk(input logic s, input logic f, input logic [63:0] t, input logic a,
                                input logic p, input logic er, input logic [63:0] ea,
                                input logic ev, input logic [63:0] ep);
        vec_t v;
        v.stall_n = s; v.flush = f; v.target = t; v.ack = a; v.push = p;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A new instruction is one that becomes valid or replaces the previous valid PC.
    task automatic sb_check();
        logic [63:0] e;
        if (m_valid && !(prev_valid && prev_pc == m_pc)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_extra: got pc %h expected no delivery", m_pc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc", m_pc, e);
                chk("sb_instr", 64'(m_instr), 64'(word(e)));
            end
        end
        prev_valid = m_valid;
        prev_pc    = m_pc;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   64'(m_req), 64'(1'b0));
        chk({tag, "_addr"},  m_addr, 64'h0);
        chk({tag, "_valid"}, 64'(m_valid), 64'(1'b0));
        chk({tag, "_pc"},    m_pc, 64'h0);
        chk({tag, "_pc4"},   m_pc4, 64'h4);
        chk({tag, "_instr"}, 64'(m_instr), 64'(NOP));
        chk({tag, "_waddr"}, w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    endtask

    initial begin
        //              st fl target      ack push req addr         vld pc
        vecs[0]  = mk(1, 0, 64'h0,   1, 0, 1, 64'h0,   0, 64'h0);
        vecs[1]  = mk(1, 0, 64'h0,   1, 1, 1, 64'h4,   1, 64'h0);
        vecs[2]  = mk(1, 0, 64'h0,   1, 1, 1, 64'h8,   1, 64'h4);
        vecs[3]  = mk(0, 0, 64'h0,   1, 1, 0, 64'h8,   1, 64'h4);
        vecs[4]  = mk(0, 0, 64'h0,   1, 0, 0, 64'h8,   1, 64'h4);
        vecs[5]  = mk(1, 0, 64'h0,   1, 0, 1, 64'hC,   1, 64'h8);
        vecs[6]  = mk(1, 0, 64'h0,   1, 1, 1, 64'h10,  1, 64'hC);
        vecs[7]  = mk(1, 1, 64'h100, 0, 0, 1, 64'h10,  0, 64'hC);
        vecs[8]  = mk(1, 0, 64'h0,   0, 0, 1, 64'h10,  0, 64'hC);
        vecs[9]  = mk(1, 0, 64'h0,   0, 0, 1, 64'h10,  0, 64'hC);
        vecs[10] = mk(1, 0, 64'h0,   1, 0, 1, 64'h100, 0, 64'hC);
        vecs[11] = mk(1, 0, 64'h0,   1, 1, 1, 64'h104, 1, 64'h100);
        vecs[12] = mk(0, 1, 64'h200, 1, 0, 1, 64'h200, 0, 64'h100);
        vecs[13] = mk(1, 0, 64'h0,   1, 1, 1, 64'h204, 1, 64'h200);
        vecs[14] = mk(1, 0, 64'h0,   0, 0, 1, 64'h204, 0, 64'h200);
        vecs[15] = mk(1, 0, 64'h0,   1, 1, 1, 64'h208, 1, 64'h204);
        vecs[16] = mk(0, 0, 64'h0,   1, 0, 0, 64'h208, 1, 64'h204);
        vecs[17] = mk(0, 1, 64'h300, 0, 0, 1, 64'h300, 0, 64'h204);
        vecs[18] = mk(1, 0, 64'h0,   1, 1, 1, 64'h304, 1, 64'h300);
        vecs[19] = mk(1, 1, 64'h400, 0, 0, 1, 64'h304, 0, 64'h300);
        vecs[20] = mk(1, 1, 64'h500, 0, 0, 1, 64'h304, 0, 64'h300);
        vecs[21] = mk(1, 1, 64'h600, 1, 0, 1, 64'h600, 0, 64'h300);
        vecs[22] = mk(1, 0, 64'h0,   1, 1, 1, 64'h604, 1, 64'h600);

        prev_valid = 1'b0;
        prev_pc    = '0;
        rst = 1'b1; stall_n = 1'b1; flush = 1'b0; target = '0; ack = 1'b0;
        step();
        step();
        chk_reset("rst");
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            stall_n = vecs[i].stall_n;
            flush   = vecs[i].flush;
            target  = vecs[i].target;
            ack     = vecs[i].ack;
            if (vecs[i].push) sb_q.push_back(i == 0 ? 64'h0 : vecs[i-1].exp_addr);
            step();
            chk($sformatf("v%0d_req", i),   64'(m_req), 64'(vecs[i].exp_req));
            chk($sformatf("v%0d_addr", i),  m_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 64'(m_valid), 64'(vecs[i].exp_valid));
            chk($sformatf("v%0d_pc", i),    m_pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_pc4", i),   m_pc4, vecs[i].exp_pc + 64'd4);
            chk($sformatf("v%0d_instr", i), 64'(m_instr),
                64'(vecs[i].exp_valid ? word(vecs[i].exp_pc) : NOP));
            sb_check();
            if (i == 0) chk("wrap_addr0", w_addr, 64'hFFFF_FFFF_FFFF_FFFC);
            if (i == 1) begin
                chk("wrap_addr1", w_addr, 64'h0);
                chk("wrap_pc",    w_pc, 64'hFFFF_FFFF_FFFF_FFFC);
                chk("wrap_pc4",   w_pc4, 64'h0);
                chk("wrap_valid", 64'(w_valid), 64'(1'b1));
            end
        end

        // Enter S_KILL, then reset with an ack landing in the reset cycle.
        stall_n = 1'b1; flush = 1'b1; target = 64'h700; ack = 1'b0;
        step();
        chk("kill_addr",  m_addr, 64'h604);
        chk("kill_valid", 64'(m_valid), 64'(1'b0));
        sb_check();
        flush = 1'b0; rst = 1'b1; ack = 1'b1;
        step();
        chk_reset("krst");
        sb_check();
        rst = 1'b0;
        step();
        chk("boot_req",   64'(m_req), 64'(1'b1));
        chk("boot_addr",  m_addr, 64'h0);
        chk("boot_valid", 64'(m_valid), 64'(1'b0));
        sb_check();
        sb_q.push_back(64'h0);
        step();
        chk("restart_addr",  m_addr, 64'h4);
        chk("restart_valid", 64'(m_valid), 64'(1'b1));
        sb_check();
        chk("sb_left", 64'(sb_q.size()), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/as_fetch_stage.md
Name: as_fetch_stage

Overview:
- Instruction-fetch stage of the RV64I in-order pipeline: owns the PC, drives the instruction-memory request/ack handshake and the IF/ID pipeline register.
- Consumes stall_n from the load-use hazard detector, which holds the PC and IF/ID.
- Consumes a redirect from execute (taken branch/jump), which flushes IF/ID and discards or kills in-flight fetches.
- Directly feeds the decode stage (if_id_* outputs, source of rs1/rs2 checked by hazard detection).

Parameters:
- XLEN, 64, address/PC width (from as_pack).
- RESET_PC, 64'h0, first fetch address after reset.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- stall_n_i  input  1  0 = hold PC and IF/ID (load-use stall).
- flush_i  input  1  1 = redirect to branch_target_i, kill younger fetches.
- branch_target_i  input  XLEN  redirect address, valid when flush_i=1.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  XLEN  fetch address; stable while imem_req_o=1 until ack.
- imem_ack_i  input  1  imem_rdata_i valid; completes current request.
- imem_rdata_i  input  32  fetched instruction word.
- if_id_valid_o  output  1  IF/ID holds a real instruction.
- if_id_pc_o  output  XLEN  PC of IF/ID instruction.
- if_id_pc4_o  output  XLEN  if_id_pc_o + 4.
- if_id_instr_o  output  32  instruction; NOP when invalid.

Behaviour:
- Reset (rst_i=1 at edge):
  - state=S_BOOT, pc_q=RESET_PC, imem_req_o=0.
  - if_id_valid_o=0, if_id_instr_o=32'h00000013 (NOP), if_id_pc_o=0, if_id_pc4_o=4.
  - Reset mid-request drops the request; a late ack is ignored while in S_BOOT.
- S_BOOT: req=0; next cycle -> S_REQ.
- S_REQ: req=1, addr=pc_q.
  - ack & flush_i: discard word; pc_q<=branch_target_i; stay S_REQ.
  - ack & !stall_n_i: word->buffer (instr, pc); IF/ID held; -> S_HOLD.
  - ack & stall_n_i: IF/ID<=(pc_q, word, valid=1); pc_q<=pc_q+4.
  - !ack & flush_i: redir_q<=branch_target_i; -> S_KILL; addr stays pc_q.
  - !ack & stall_n_i: IF/ID loads bubble (valid=0, NOP).
- S_KILL: req=1, addr unchanged.
  - Further flush_i overwrites redir_q.
  - On ack, word is discarded, pc_q<=redir_q (or branch_target_i if flush_i is also set that cycle), -> S_REQ.
- S_HOLD: req=0.
  - flush_i: drop buffer, pc_q<=branch_target_i, -> S_REQ.
  - stall_n_i=1: IF/ID<=buffer, valid=1; pc_q<=buf_pc+4; -> S_REQ.
  - else: stay.
- IF/ID update priority (per edge): rst_i > flush_i (valid=0, NOP, pc fields unchanged) > !stall_n_i (hold all) > load/bubble as above.
- PC arithmetic: modulo 2^XLEN; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0. branch_target_i is used as given, with no alignment check.
- Latency:
  - Ack in cycle N -> if_id_valid_o=1 from cycle N+1.
  - With a single-cycle ack, one instruction per cycle is sustained.
  - First request is issued in the 2nd cycle after reset release.

Decomposition:
- as_pack additions: fetch_state_t enum {S_BOOT,S_REQ,S_KILL,S_HOLD}; NOP_INSTR=32'h00000013; XLEN.
- Sub-module as_if_id_reg: IF/ID register with flush/hold/load/bubble controls and pc4 generation.
- FSM, PC, redirect register and buffer stay in as_fetch_stage.

Test Plan:
- Reset release, ack tied 1 -> imem_addr_o sequence 0,4,8,C; if_id_pc_o follows one cycle later with valid=1.
- stall_n_i=0 for 2 cycles while ack=1 at addr 8 -> IF/ID holds addr 4; word@8 is buffered; req=0. On release, IF/ID=8 and the next request is C.
- flush_i with target 0x100 while request at 0x10 is unacked (ack 3 cycles later) -> addr stays 0x10 until ack. Word is dropped and never valid; next addr=0x100; if_id_valid_o=0 after the flush.
- flush_i and stall_n_i=0 in the same cycle -> IF/ID invalid with NOP; next fetch from target.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch addr 0; if_id_pc4_o=0 for the first instruction.
- rst_i asserted during S_KILL with ack arriving in the reset cycle -> all outputs at reset values; no valid instruction; fetch restarts at RESET_PC.
